// File: rtl/nios_pio_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : nios_pio_pkg
//  Purpose  : Shared constants for the NIOS input PIO. Holds the register
//             word addresses, the edge-select encodings and the STATUS
//             register field positions, plus a STATUS packing helper.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package nios_pio_pkg;

  // Register word addresses
  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_IRQMASK = 3'd1;
  localparam logic [2:0] ADDR_EDGECAP = 3'd2;
  localparam logic [2:0] ADDR_FIFO    = 3'd3;
  localparam logic [2:0] ADDR_STATUS  = 3'd4;

  // EDGE_TYPE encodings
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // STATUS register layout
  localparam int STATUS_COUNT_W       = 7;
  localparam int STATUS_FIFO_IE_BIT   = 16;
  localparam int STATUS_OVERFLOW_BIT  = 31;

  function automatic logic [31:0] status_word(input logic [STATUS_COUNT_W-1:0] count,
                                              input logic                      fifo_ie,
                                              input logic                      overflow);
    logic [31:0] w_word;
    w_word                          = '0;
    w_word[STATUS_COUNT_W-1:0]      = count;
    w_word[STATUS_FIFO_IE_BIT]      = fifo_ie;
    w_word[STATUS_OVERFLOW_BIT]     = overflow;
    return w_word;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nios_pio_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : nios_pio_fifo
//  Purpose  : Synchronous show-ahead FIFO for recording input-bus changes.
//             A push while full is accepted only if a pop happens in the same
//             cycle; otherwise it is dropped (the caller flags overflow).
//             A pop while empty is ignored.
//  Ports    : clk, reset_n (async, active low)
//             push, din        - write request and data
//             pop              - read request (head advances)
//             dout             - current head entry (valid when !empty)
//             count/full/empty - occupancy
//  Revision : 1.0  initial release
// ============================================================================
module nios_pio_fifo
  import nios_pio_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      push,
  input  logic                      pop,
  input  logic [WIDTH-1:0]          din,
  output logic [WIDTH-1:0]          dout,
  output logic [STATUS_COUNT_W-1:0] count,
  output logic                      full,
  output logic                      empty
);

  localparam int                      AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [STATUS_COUNT_W-1:0] C_DEPTH = STATUS_COUNT_W'(DEPTH);

  logic [WIDTH-1:0]          r_mem [DEPTH];
  logic [AW-1:0]             r_wptr;
  logic [AW-1:0]             r_rptr;
  logic [STATUS_COUNT_W-1:0] r_count;
  logic                      w_pop;
  logic                      w_push;

  assign full  = (r_count == C_DEPTH);
  assign empty = (r_count == '0);
  assign count = r_count;
  assign dout  = r_mem[r_rptr];

  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign w_pop  = pop & ~empty;
  assign w_push = push & (~full | w_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + STATUS_COUNT_W'(1);
        2'b01:   r_count <= r_count - STATUS_COUNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible once counted
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/nios_pio_in_capture.sv
`default_nettype none
// ============================================================================
//  Module   : nios_pio_in_capture
//  Purpose  : Avalon-MM input PIO. Synchronises in_port, exposes its level,
//             latches selected edges into a W1C capture register, records
//             every bus change in a FIFO and drives a maskable interrupt.
//  Ports    : clk, reset_n (async, active low)
//             chipselect, address[2:0], read, write, writedata[31:0]
//             readdata[31:0] - registered, latency 1
//             in_port[WIDTH-1:0] - asynchronous inputs
//             irq - registered interrupt
//  Revision : 1.0  initial release
// ============================================================================
module nios_pio_in_capture
  import nios_pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0,
  parameter int DEPTH       = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             chipselect,
  input  logic [2:0]       address,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync_chain;
  logic [WIDTH-1:0]          w_sync;
  logic [WIDTH-1:0]          r_prev;
  logic [WIDTH-1:0]          w_rise;
  logic [WIDTH-1:0]          w_fall;
  logic [WIDTH-1:0]          w_edge;
  logic [WIDTH-1:0]          r_irqmask;
  logic [WIDTH-1:0]          r_edgecap;
  logic [WIDTH-1:0]          w_ec_clr;
  logic                      r_fifo_ie;
  logic                      r_overflow;
  logic                      w_wr;
  logic                      w_rd;
  logic                      w_push;
  logic                      w_pop_req;
  logic                      w_ovf_set;
  logic [WIDTH-1:0]          w_fifo_dout;
  logic [STATUS_COUNT_W-1:0] w_count;
  logic                      w_full;
  logic                      w_empty;
  logic [31:0]               w_rdata;
  logic                      w_unused_ok;

  // --------------------------------------------------------------------------
  // Synchroniser and edge detection
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync_chain <= '0;
      r_prev       <= '0;
    end else begin
      r_sync_chain <= {r_sync_chain[SYNC_STAGES-2:0], in_port};
      r_prev       <= w_sync;
    end
  end

  assign w_sync = r_sync_chain[SYNC_STAGES-1];
  assign w_rise = w_sync & ~r_prev;
  assign w_fall = ~w_sync & r_prev;

  generate
    if (EDGE_TYPE == EDGE_RISE) begin : g_edge_rise
      assign w_edge = w_rise;
    end else if (EDGE_TYPE == EDGE_FALL) begin : g_edge_fall
      assign w_edge = w_fall;
    end else begin : g_edge_any
      assign w_edge = w_rise | w_fall;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Change FIFO
  // --------------------------------------------------------------------------
  assign w_wr      = chipselect & write;
  assign w_rd      = chipselect & read;
  assign w_push    = (w_sync != r_prev);
  assign w_pop_req = w_rd & (address == ADDR_FIFO);
  // Full implies non-empty, so any pop request frees a slot for the push
  assign w_ovf_set = w_push & w_full & ~w_pop_req;

  nios_pio_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (w_push),
    .pop     (w_pop_req),
    .din     (w_sync),
    .dout    (w_fifo_dout),
    .count   (w_count),
    .full    (w_full),
    .empty   (w_empty)
  );

  // --------------------------------------------------------------------------
  // Register file
  // --------------------------------------------------------------------------
  assign w_ec_clr = (w_wr && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irqmask  <= '0;
      r_edgecap  <= '0;
      r_fifo_ie  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr && address == ADDR_IRQMASK) r_irqmask <= writedata[WIDTH-1:0];
      // New edges win over a coincident W1C clear
      r_edgecap <= (r_edgecap & ~w_ec_clr) | w_edge;
      if (w_wr && address == ADDR_STATUS) r_fifo_ie <= writedata[STATUS_FIFO_IE_BIT];
      if (w_ovf_set)
        r_overflow <= 1'b1;
      else if (w_wr && address == ADDR_STATUS && writedata[STATUS_OVERFLOW_BIT])
        r_overflow <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Read mux (registered every clock) and interrupt
  // --------------------------------------------------------------------------
  always_comb begin
    w_rdata = '0;
    case (address)
      ADDR_DATA:    w_rdata = 32'(w_sync);
      ADDR_IRQMASK: w_rdata = 32'(r_irqmask);
      ADDR_EDGECAP: w_rdata = 32'(r_edgecap);
      ADDR_FIFO:    w_rdata = w_empty ? 32'd0 : 32'(w_fifo_dout);
      ADDR_STATUS:  w_rdata = status_word(w_count, r_fifo_ie, r_overflow);
      default:      w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      readdata <= w_rdata;
      irq      <= (|(r_edgecap & r_irqmask)) | (r_fifo_ie & ~w_empty);
    end
  end

  // Writedata bits outside the implemented fields are intentionally ignored
  assign w_unused_ok = &{1'b0, writedata};

endmodule
`default_nettype wire

// File: doc/nios_pio_in_capture.md
# nios_pio_in_capture

Parametrised Avalon-MM input PIO for the NIOS subsystem. It synchronises a WIDTH-bit external input bus (I2C data-in, encoders, limit switches) and exposes the current level. It latches selected edges into a write-1-to-clear capture register and raises a maskable interrupt. Every change of the synchronised bus is recorded in a small FIFO, so software can read back bursts of input changes without polling each one.

## Interface
Parameters:
- WIDTH, 8: input bus width, 1..32.
- SYNC_STAGES, 2: synchroniser depth, 2..4.
- EDGE_TYPE, 0: edge captured; 0 = rising, 1 = falling, 2 = any.
- DEPTH, 8: change-FIFO entries, power of two, 2..64.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- chipselect  in  1  slave select.
- address  in  3  word address.
- read  in  1  read strobe, qualified by chipselect.
- write  in  1  write strobe, qualified by chipselect.
- writedata  in  32  write data.
- readdata  out  32  registered read data; reset value 0.
- in_port  in  WIDTH  asynchronous external inputs.
- irq  out  1  registered interrupt, active high; reset value 0.

## Operation
- Register map; all reads are zero-extended, and unlisted bits read 0:
  - Address 0 DATA (RO): synchronised level `sync`.
  - Address 1 IRQMASK (RW, WIDTH bits): edge interrupt mask.
  - Address 2 EDGECAP (RW1C): write a 1 to a bit to clear it.
  - Address 3 FIFO (RO, pop on read): head entry.
  - Address 4 STATUS: bits [6:0] count (RO); bit 16 fifo_ie (RW); bit 31 overflow (sticky, W1C).
  - Addresses 5..7 read 0 and ignore writes.
- Synchroniser: in_port passes through SYNC_STAGES flops to give `sync`; `prev` holds `sync` from the previous clock. Both reset to 0.
- Edge detect, per bit:
  - rise = sync & ~prev
  - fall = ~sync & prev
  - The selected edge sets the EDGECAP bit.
  - On a simultaneous set and W1C clear of the same bit, set wins.
- Change FIFO:
  - Push when sync != prev; the pushed value is `sync`.
  - Pop on chipselect & read & address==3 when count > 0.
  - Push when full: value dropped, overflow set.
  - Simultaneous push and pop when full: both occur, no overflow.
  - Pop when empty: readdata = 0, no state change.
- irq next-state = |(EDGECAP & IRQMASK) | (fifo_ie & count != 0).
- Reset mid-operation clears sync, prev, EDGECAP, IRQMASK, fifo_ie, FIFO pointers/count, overflow, readdata and irq immediately.
- Because prev resets to 0, an input already high at reset release produces a rising edge and a FIFO push once it reaches `sync`.

## Timing
- readdata is registered every clock from the address mux: data for address A presented at edge k is visible after edge k. Read wait-states 0, read latency 1.
- Reading FIFO returns the entry removed by that same pop.
- Writes take effect at the clock edge where chipselect & write is high.
- An in_port change sampled at edge N reaches `sync` after edge N+SYNC_STAGES-1. EDGECAP and the FIFO update at edge N+SYNC_STAGES; irq updates at edge N+SYNC_STAGES+1.
- Clearing the last contributing EDGECAP bit or the mask drops irq one edge after the write.
- count is DEPTH max; the pointers wrap modulo DEPTH.

## Structure
- Shared package nios_pio_pkg holds:
  - Address constants ADDR_DATA..ADDR_STATUS.
  - EDGE_RISE / EDGE_FALL / EDGE_ANY constants.
  - STATUS bit positions (count [6:0], fifo_ie 16, overflow 31).
- One sub-module, nios_pio_fifo:
  - Parameters WIDTH and DEPTH; synchronous FIFO, show-ahead head.
  - Ports push, pop, din, dout, count, full, empty; same clk/reset_n.
- Top level contains the synchroniser, edge logic, register file, read mux and irq.

## Test plan
- Reset with in_port=8'h00, then drive 8'hA5 → DATA reads 8'hA5 three cycles later (SYNC_STAGES=2). EDGECAP = 8'hA5, FIFO holds one entry 8'hA5, count=1.
- IRQMASK=8'h01, rise on bit0 → irq=1 at N+3. Write EDGECAP=8'h01 → irq=0 one edge later. On a same-cycle new edge plus clear, the bit stays set.
- EDGE_TYPE=1, 8'hFF→8'h0F → EDGECAP=8'hF0. EDGE_TYPE=2, toggle bit3 twice → bit3 set and one EDGECAP clear needed.
- DEPTH=8, 9 changes without reads → count=8, overflow=1, entries are the first 8 values. Pop once plus a same-cycle push → count stays 8, overflow unchanged. Write STATUS bit31=1 → overflow=0.
- Pop on an empty FIFO → readdata=0 and count stays 0. fifo_ie=1 with one push → irq=1; pop it → irq=0.
- Assert reset_n low mid-burst with count=5 and irq=1 → readdata, irq and count are 0 immediately; after release, in_port=8'h80 held produces a FIFO entry 8'h80.
